// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan driver.
// Segment patterns are active-high {g,f,e,d,c,b,a}; polarity is applied at the pins.
package seg7_pkg;

  typedef logic [1:0] idx_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // XOR masks that turn an active-high pattern into pin levels
  function automatic logic [6:0] pol_mask7(input bit active_low);
    return active_low ? 7'h7F : 7'h00;
  endfunction

  function automatic logic [3:0] pol_mask4(input bit active_low);
    return active_low ? 4'hF : 4'h0;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Digit inputs and display pins of the scan driver, bundled for port connection.
// master = display-select side / board model, slave = the scan driver.
interface seg7_scan_driver_if;

  logic [3:0] dig1;
  logic [3:0] dig2;
  logic [3:0] dig3;
  logic [3:0] dig4;
  logic [3:0] dp_in;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_start;

  modport master (
    output dig1, dig2, dig3, dig4, dp_in,
    input  an, seg, dp, frame_start
  );

  modport slave (
    input  dig1, dig2, dig3, dig4, dp_in,
    output an, seg, dp, frame_start
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational BCD to active-high 7-segment decoder; 10..15 show a dash,
// and blank forces all segments off.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    if (blank) begin
      pattern = SEG_BLANK;
    end else begin
      case (value)
        4'd0:    pattern = SEG_0;
        4'd1:    pattern = SEG_1;
        4'd2:    pattern = SEG_2;
        4'd3:    pattern = SEG_3;
        4'd4:    pattern = SEG_4;
        4'd5:    pattern = SEG_5;
        4'd6:    pattern = SEG_6;
        4'd7:    pattern = SEG_7;
        4'd8:    pattern = SEG_8;
        4'd9:    pattern = SEG_9;
        default: pattern = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit time-multiplexed 7-segment driver with per-frame snapshot.
// Optional leading-zero suppression when SEG7_LZ_BLANK_EN is defined.
//
//   idx | meaning
//   0   | digit 0 (rightmost, dig1) active; 3->0 wrap takes the snapshot
//   1   | digit 1 (dig2) active
//   2   | digit 2 (dig3) active
//   3   | digit 3 (leftmost, dig4) active
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int REFRESH_HZ     = 1000,
  parameter bit ACTIVE_LOW_SEG = 1'b1,
  parameter bit ACTIVE_LOW_AN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  seg7_scan_driver_if.slave  disp
);

  localparam int TICK_DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_TC = PW'(TICK_DIV - 1);
  localparam logic [6:0] SEG_INV = pol_mask7(ACTIVE_LOW_SEG);
  localparam logic [3:0] AN_INV  = pol_mask4(ACTIVE_LOW_AN);
  localparam logic       DP_INV  = ACTIVE_LOW_SEG;

  logic [PW-1:0]   prescaler;
  idx_t            idx;
  logic            running;
  logic [3:0][3:0] snap_dig;
  logic [3:0]      snap_dp;
  logic [3:0]      blank_vec;
  logic            tick;
  logic [6:0]      pattern;

  logic [3:0]      an_q;
  logic [6:0]      seg_q;
  logic            dp_q;
  logic            frame_start_q;

  assign tick = (prescaler == TICK_TC);

  always_comb begin
    blank_vec = 4'b0000;
`ifdef SEG7_LZ_BLANK_EN
    blank_vec[3] = (snap_dig[3] == 4'd0);
    blank_vec[2] = (snap_dig[2] == 4'd0) && blank_vec[3];
    blank_vec[1] = (snap_dig[1] == 4'd0) && blank_vec[2];
`endif
  end

  seg7_decode u_decode (
    .value   (snap_dig[idx]),
    .blank   (blank_vec[idx]),
    .pattern (pattern)
  );

  // Output registers sample idx/snapshot together so an and seg never skew
  always_ff @(posedge clk) begin
    if (rst) begin
      prescaler     <= '0;
      idx           <= 2'd0;
      running       <= 1'b0;
      snap_dig      <= '0;
      snap_dp       <= 4'b0000;
      an_q          <= AN_INV;
      seg_q         <= SEG_INV;
      dp_q          <= DP_INV;
      frame_start_q <= 1'b0;
    end else begin
      prescaler     <= tick ? '0 : prescaler + 1'b1;
      frame_start_q <= 1'b0;
      if (tick) begin
        idx     <= idx + 2'd1;
        running <= 1'b1;
        if (idx == 2'd3) begin
          snap_dig      <= {disp.dig4, disp.dig3, disp.dig2, disp.dig1};
          snap_dp       <= disp.dp_in;
          frame_start_q <= 1'b1;
        end
      end
      an_q  <= (running ? (4'b0001 << idx) : 4'b0000) ^ AN_INV;
      seg_q <= pattern ^ SEG_INV;
      dp_q  <= snap_dp[idx] ^ DP_INV;
    end
  end

  assign disp.an          = an_q;
  assign disp.seg         = seg_q;
  assign disp.dp          = dp_q;
  assign disp.frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver with a queue of expected per-digit outputs.
// Expected values follow SEG7_LZ_BLANK_EN when the build defines it.
module tb_seg7_scan_driver;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if bus ();

  seg7_scan_driver #(
    .CLK_HZ         (16),
    .REFRESH_HZ     (4),
    .ACTIVE_LOW_SEG (1'b1),
    .ACTIVE_LOW_AN  (1'b1)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .disp (bus)
  );

`ifdef SEG7_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected values are given active-high and converted to pin levels here
  task automatic push(input string tag, input logic [3:0] an, input logic [6:0] seg_ah,
                      input logic dp_ah);
    exp_t e;
    e.tag = tag;
    e.an  = an;
    e.seg = ~seg_ah;
    e.dp  = ~dp_ah;
    sb.push_back(e);
  endtask

  task automatic wait_an(input logic [3:0] target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.an === target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_fs(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_fs_seen"}, {7'd0, ok}, 8'd1);
  endtask

  task automatic pop_check();
    exp_t e;
    bit   ok;
    e = sb.pop_front();
    wait_an(e.an, 40, ok);
    check({e.tag, "_reached"}, {7'd0, ok}, 8'd1);
    check({e.tag, "_an"}, {4'd0, bus.an}, {4'd0, e.an});
    check({e.tag, "_seg"}, {1'b0, bus.seg}, {1'b0, e.seg});
    check({e.tag, "_dp"}, {7'd0, bus.dp}, {7'd0, e.dp});
  endtask

  task automatic check_off(input string tag);
    check({tag, "_an"}, {4'd0, bus.an}, 8'h0F);
    check({tag, "_seg"}, {1'b0, bus.seg}, 8'h7F);
    check({tag, "_dp"}, {7'd0, bus.dp}, 8'h01);
    check({tag, "_fs"}, {7'd0, bus.frame_start}, 8'h00);
  endtask

  // Release reset at a negedge and confirm the first anode appears on the 5th edge
  task automatic release_and_check_start(input string tag, input logic [6:0] seg_pin_exp,
                                         input logic dp_pin_exp);
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) @(negedge clk);
    check({tag, "_pre_tick_an"}, {4'd0, bus.an}, 8'h0F);
    @(negedge clk);
    check({tag, "_first_an"}, {4'd0, bus.an}, 8'h0D);
    check({tag, "_first_seg"}, {1'b0, bus.seg}, {1'b0, seg_pin_exp});
    check({tag, "_first_dp"}, {7'd0, bus.dp}, {7'd0, dp_pin_exp});
  endtask

  initial begin
    int  n;
    bit  ok;
    bus.dig1  = 4'd0;
    bus.dig2  = 4'd0;
    bus.dig3  = 4'd0;
    bus.dig4  = 4'd0;
    bus.dp_in = 4'b0000;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_off("reset");

    bus.dig4  = 4'd1;
    bus.dig3  = 4'd2;
    bus.dig2  = 4'd3;
    bus.dig1  = 4'd4;
    bus.dp_in = 4'b0100;
    // snapshot is still cleared: idx1 shows 0 (blank under leading-zero suppression)
    release_and_check_start("start", LZ ? 7'h7F : 7'h40, 1'b1);

    wait_fs("frame1");
    @(negedge clk);
    check("fs_width", {7'd0, bus.frame_start}, 8'h00);
    n = 1;
    while (bus.frame_start !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("fs_period", n[7:0], 8'd16);

    push("d1234_idx0", 4'b1110, 7'h66, 1'b0);
    push("d1234_idx1", 4'b1101, 7'h4F, 1'b0);
    push("d1234_idx2", 4'b1011, 7'h5B, 1'b1);
    push("d1234_idx3", 4'b0111, 7'h06, 1'b0);
    repeat (4) pop_check();

    wait_fs("midframe");
    bus.dig1 = 4'd9;
    push("stale_idx0", 4'b1110, 7'h66, 1'b0);
    pop_check();
    wait_fs("newframe");
    push("new_idx0", 4'b1110, 7'h6F, 1'b0);
    pop_check();

    bus.dig2 = 4'hC;
    wait_fs("dash");
    push("dash_idx1", 4'b1101, 7'h40, 1'b0);
    pop_check();

    bus.dig4  = 4'd0;
    bus.dig3  = 4'd0;
    bus.dig2  = 4'd5;
    bus.dig1  = 4'd0;
    bus.dp_in = 4'b1000;
    wait_fs("lz");
    push("lz_idx0", 4'b1110, 7'h3F, 1'b0);
    push("lz_idx1", 4'b1101, 7'h6D, 1'b0);
    push("lz_idx2", 4'b1011, LZ ? 7'h00 : 7'h3F, 1'b0);
    push("lz_idx3", 4'b0111, LZ ? 7'h00 : 7'h3F, 1'b1);
    repeat (4) pop_check();

    bus.dig4  = 4'd8;
    bus.dig3  = 4'd8;
    bus.dig2  = 4'd8;
    bus.dig1  = 4'd8;
    bus.dp_in = 4'b1111;
    wait_an(4'b1011, 40, ok);
    check("rst_mid_at_idx2", {7'd0, ok}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    check_off("rst_mid");
    release_and_check_start("restart", LZ ? 7'h7F : 7'h40, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
